id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/arm_pkg.sv | 66 ++++++
 rtl/regfile_bypass.sv | 74 +++++++
 rtl/id_stage_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared constants for the instruction-decode stage: the execute-unit command
// encodings, the data-processing opcodes, the instruction mode field and the
// ARM condition codes. Imported by the decode stage and its register file.
// -----------------------------------------------------------------------------
package arm_pkg;

    // Execute-unit command handed down the pipe in exe_cmd.
    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    // Data-processing opcode field instr[24:21].
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_EOR = 4'b0001,
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0100,
        OP_ADC = 4'b0101,
        OP_SBC = 4'b0110,
        OP_TST = 4'b1000,
        OP_CMP = 4'b1010,
        OP_ORR = 4'b1100,
        OP_MOV = 4'b1101,
        OP_MVN = 4'b1111
    } opcode_e;

    // Instruction class field instr[27:26].
    typedef enum logic [1:0] {
        MODE_DP     = 2'b00,
        MODE_MEM    = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Condition field instr[31:28].
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/regfile_bypass.sv
// -----------------------------------------------------------------------------
// regfile_bypass
// Register file with two combinational read ports and one clocked write port.
// With BYPASS_EN set, a write landing on a register that is being read in the
// same cycle is forwarded straight to the read port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all entries)
//   rd_addr_a/_b [3:0]  read addresses; addresses >= NUM_REGS read as 0
//   rd_data_a/_b        read data
//   wr_en, wr_addr      write strobe and address; addresses >= NUM_REGS ignored
//   wr_data             write data
// -----------------------------------------------------------------------------
module regfile_bypass
    import arm_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // The 4-bit architectural address space may be larger than the physical
    // file, so every access is qualified by this range check.
    function automatic logic in_range(input logic [3:0] addr);
        return ({1'b0, addr} < 5'(NUM_REGS));
    endfunction

    // Write port. Reset wins over a coincident write, so the write is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && in_range(wr_addr)) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Read ports: out-of-range reads give 0, then optional forwarding of the
    // write that is about to land, otherwise the stored contents.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (in_range(rd_addr_a)) begin
            if ((BYPASS_EN != 0) && wr_en && (wr_addr == rd_addr_a)) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = regs[rd_addr_a[AW-1:0]];
            end
        end
        if (in_range(rd_addr_b)) begin
            if ((BYPASS_EN != 0) && wr_en && (wr_addr == rd_addr_b)) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = regs[rd_addr_b[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
// Instruction-decode stage with its output pipeline register. Decodes an ARM
// style instruction, checks its condition against the status flags, reads the
// two source operands and registers everything for the execute stage.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, pc_in          incoming instruction valid and its PC
//   instruction [31:0]       instruction word
//   hazard                   hazard-unit request to squash this instruction
//   stall                    downstream hold: registered outputs keep their value
//   flush                    branch-taken kill: load a bubble (beats stall)
//   sr [3:0]                 status flags {N,Z,C,V}
//   wb_wb_en/dest/value      write-back port into the register file
//   out_valid .. dest        registered decode results for the execute stage
//   two_src, src_1, src_2    combinational source info for the hazard unit
// -----------------------------------------------------------------------------
module id_stage_pipe
    import arm_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [31:0]       instruction,
    input  logic              hazard,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        sr,
    input  logic              wb_wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              out_valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] value_rn,
    output logic [DATA_W-1:0] value_rm,
    output logic [11:0]       shift_operand,
    output logic              imm,
    output logic [23:0]       imm_signed_24,
    output logic [3:0]        dest,
    output logic              two_src,
    output logic [3:0]        src_1,
    output logic [3:0]        src_2
);

    logic [3:0] cond_f;
    logic [1:0] mode_f;
    logic       i_bit;
    logic [3:0] opcode_f;
    logic       s_bit;
    logic [3:0] rn_f;
    logic [3:0] rd_f;
    logic [3:0] rm_f;

    assign cond_f   = instruction[31:28];
    assign mode_f   = instruction[27:26];
    assign i_bit    = instruction[25];
    assign opcode_f = instruction[24:21];
    assign s_bit    = instruction[20];
    assign rn_f     = instruction[19:16];
    assign rd_f     = instruction[15:12];
    assign rm_f     = instruction[3:0];

    logic       is_str;
    logic       cond_pass;
    logic       kill;
    logic [3:0] dec_exe;
    logic       dec_wb;
    logic       dec_mem_r;
    logic       dec_mem_w;
    logic       dec_b;
    logic       dec_s;
    logic [DATA_W-1:0] rf_rn;
    logic [DATA_W-1:0] rf_rm;

    // A store reads its data register through rd rather than rm, so the second
    // source switches on the raw decode, before any kill gating.
    assign is_str  = (mode_f == MODE_MEM) && !s_bit;
    assign src_1   = rn_f;
    assign src_2   = is_str ? rd_f : rm_f;
    assign two_src = !i_bit || is_str;

    // Condition check against the status flags {N,Z,C,V}.
    always_comb begin
        cond_pass = 1'b0;
        case (cond_f)
            COND_EQ: cond_pass = sr[2];
            COND_NE: cond_pass = !sr[2];
            COND_CS: cond_pass = sr[1];
            COND_CC: cond_pass = !sr[1];
            COND_MI: cond_pass = sr[3];
            COND_PL: cond_pass = !sr[3];
            COND_VS: cond_pass = sr[0];
            COND_VC: cond_pass = !sr[0];
            COND_HI: cond_pass = sr[1] && !sr[2];
            COND_LS: cond_pass = !sr[1] || sr[2];
            COND_GE: cond_pass = (sr[3] == sr[0]);
            COND_LT: cond_pass = (sr[3] != sr[0]);
            COND_GT: cond_pass = !sr[2] && (sr[3] == sr[0]);
            COND_LE: cond_pass = sr[2] || (sr[3] != sr[0]);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Control decode. Anything not listed (reserved mode, unknown opcode)
    // leaves every control at 0, including the S flag.
    always_comb begin
        dec_exe   = EXE_NOP;
        dec_wb    = 1'b0;
        dec_mem_r = 1'b0;
        dec_mem_w = 1'b0;
        dec_b     = 1'b0;
        dec_s     = 1'b0;
        case (mode_f)
            MODE_DP: begin
                case (opcode_f)
                    OP_MOV: begin dec_exe = EXE_MOV; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_MVN: begin dec_exe = EXE_MVN; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_ADD: begin dec_exe = EXE_ADD; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_ADC: begin dec_exe = EXE_ADC; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_SUB: begin dec_exe = EXE_SUB; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_SBC: begin dec_exe = EXE_SBC; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_AND: begin dec_exe = EXE_AND; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_ORR: begin dec_exe = EXE_ORR; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_EOR: begin dec_exe = EXE_EOR; dec_wb = 1'b1; dec_s = s_bit; end
                    OP_CMP: begin dec_exe = EXE_SUB; dec_s = s_bit; end
                    OP_TST: begin dec_exe = EXE_AND; dec_s = s_bit; end
                    default: ;
                endcase
            end
            MODE_MEM: begin
                dec_exe = EXE_ADD;
                if (s_bit) begin
                    dec_mem_r = 1'b1;
                    dec_wb    = 1'b1;
                end else begin
                    dec_mem_w = 1'b1;
                end
            end
            MODE_BRANCH: dec_b = 1'b1;
            default: ;
        endcase
    end

    // A killed instruction still travels down the pipe but with no side effects.
    assign kill = hazard || !cond_pass || !in_valid;

    regfile_bypass #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .BYPASS_EN (BYPASS_EN)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (src_1),
        .rd_addr_b (src_2),
        .rd_data_a (rf_rn),
        .rd_data_b (rf_rm),
        .wr_en     (wb_wb_en),
        .wr_addr   (wb_dest),
        .wr_data   (wb_value)
    );

    // Output pipeline register. Reset and flush both load an all-zero bubble;
    // stall freezes every field; otherwise the decode result is captured.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid     <= 1'b0;
            wb_en         <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            exe_cmd       <= '0;
            pc            <= '0;
            value_rn      <= '0;
            value_rm      <= '0;
            shift_operand <= '0;
            imm           <= 1'b0;
            imm_signed_24 <= '0;
            dest          <= '0;
        end else if (!stall) begin
            out_valid     <= in_valid && !hazard;
            wb_en         <= kill ? 1'b0 : dec_wb;
            mem_r_en      <= kill ? 1'b0 : dec_mem_r;
            mem_w_en      <= kill ? 1'b0 : dec_mem_w;
            b             <= kill ? 1'b0 : dec_b;
            s             <= kill ? 1'b0 : dec_s;
            exe_cmd       <= kill ? 4'b0000 : dec_exe;
            pc            <= pc_in;
            value_rn      <= rf_rn;
            value_rm      <= rf_rm;
            shift_operand <= instruction[11:0];
            imm           <= i_bit;
            imm_signed_24 <= instruction[23:0];
            dest          <= rd_f;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
// Drives two copies of the decode stage from the same inputs: one with the
// default configuration, one with a small 8-entry file and no forwarding.
// Both are compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, hazard, stall, flush;
    logic [31:0] pc_in, instruction;
    logic [3:0]  sr;
    logic        wb_wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;

    logic        a_out_valid, a_wb_en, a_mem_r_en, a_mem_w_en, a_b, a_s, a_imm, a_two_src;
    logic [3:0]  a_exe_cmd, a_dest, a_src_1, a_src_2;
    logic [31:0] a_pc, a_value_rn, a_value_rm;
    logic [11:0] a_shift_operand;
    logic [23:0] a_imm_signed_24;

    logic        b_out_valid, b_wb_en, b_mem_r_en, b_mem_w_en, b_b, b_s, b_imm, b_two_src;
    logic [3:0]  b_exe_cmd, b_dest, b_src_1, b_src_2;
    logic [31:0] b_pc, b_value_rn, b_value_rm;
    logic [11:0] b_shift_operand;
    logic [23:0] b_imm_signed_24;

    int checkCount = 0;
    int passCount  = 0;

    // Expected registered state of one stage.
    typedef struct packed {
        logic        ov, wb, mr, mw, b, s;
        logic [3:0]  exe;
        logic [31:0] pc, vrn, vrm;
        logic [11:0] sh;
        logic        imm;
        logic [23:0] i24;
        logic [3:0]  dest;
    } exp_t;

    exp_t expA, expB, obsA, obsB, frozen;
    logic [31:0] regsA [16];
    logic [31:0] regsB [16];
    logic [3:0]  opExe  [16];
    bit          opKnown[16];
    bit          opWb   [16];

    assign obsA = {a_out_valid, a_wb_en, a_mem_r_en, a_mem_w_en, a_b, a_s, a_exe_cmd,
                   a_pc, a_value_rn, a_value_rm, a_shift_operand, a_imm, a_imm_signed_24, a_dest};
    assign obsB = {b_out_valid, b_wb_en, b_mem_r_en, b_mem_w_en, b_b, b_s, b_exe_cmd,
                   b_pc, b_value_rn, b_value_rm, b_shift_operand, b_imm, b_imm_signed_24, b_dest};

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .instruction(instruction),
        .hazard(hazard), .stall(stall), .flush(flush), .sr(sr),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .out_valid(a_out_valid), .wb_en(a_wb_en), .mem_r_en(a_mem_r_en), .mem_w_en(a_mem_w_en),
        .b(a_b), .s(a_s), .exe_cmd(a_exe_cmd), .pc(a_pc), .value_rn(a_value_rn),
        .value_rm(a_value_rm), .shift_operand(a_shift_operand), .imm(a_imm),
        .imm_signed_24(a_imm_signed_24), .dest(a_dest),
        .two_src(a_two_src), .src_1(a_src_1), .src_2(a_src_2)
    );

    id_stage_pipe #(.DATA_W(32), .NUM_REGS(8), .BYPASS_EN(0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .instruction(instruction),
        .hazard(hazard), .stall(stall), .flush(flush), .sr(sr),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .out_valid(b_out_valid), .wb_en(b_wb_en), .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en),
        .b(b_b), .s(b_s), .exe_cmd(b_exe_cmd), .pc(b_pc), .value_rn(b_value_rn),
        .value_rm(b_value_rm), .shift_operand(b_shift_operand), .imm(b_imm),
        .imm_signed_24(b_imm_signed_24), .dest(b_dest),
        .two_src(b_two_src), .src_1(b_src_1), .src_2(b_src_2)
    );

    always #5 clk = ~clk;

    // The one place a comparison is counted and reported.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // ARM condition truth table built as a vector indexed by the condition code.
    function automatic bit condOk(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        bit [15:0] t;
        {n, z, cy, v} = f;
        t = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~cy | z, cy & ~z,
             ~v, v, ~n, n, ~cy, cy, ~z, z};
        return t[c];
    endfunction

    function automatic logic [31:0] modelRead(input bit nb, input logic [3:0] a);
        int depth = nb ? 8 : 16;
        if (int'(a) >= depth) return 32'h0;
        if (!nb && wb_wb_en && wb_dest == a) return wb_value;
        return nb ? regsB[a] : regsA[a];
    endfunction

    // Next registered state given the current inputs.
    function automatic exp_t modelNext(input exp_t cur, input bit nb);
        exp_t n;
        bit   live, str;
        logic [3:0] op;
        n = '0;
        if (rst || flush) return n;
        if (stall) return cur;
        op   = instruction[24:21];
        str  = (instruction[27:26] == 2'b01) && !instruction[20];
        live = in_valid && !hazard && condOk(instruction[31:28], sr);
        n.ov = in_valid && !hazard;
        if (live) begin
            if (instruction[27:26] == 2'b00 && opKnown[op]) begin
                n.exe = opExe[op];
                n.wb  = opWb[op];
                n.s   = instruction[20];
            end else if (instruction[27:26] == 2'b01) begin
                n.exe = 4'b0010;
                n.mr  = instruction[20];
                n.wb  = instruction[20];
                n.mw  = !instruction[20];
            end else if (instruction[27:26] == 2'b10) begin
                n.b = 1'b1;
            end
        end
        n.pc   = pc_in;
        n.vrn  = modelRead(nb, instruction[19:16]);
        n.vrm  = modelRead(nb, str ? instruction[15:12] : instruction[3:0]);
        n.sh   = instruction[11:0];
        n.imm  = instruction[25];
        n.i24  = instruction[23:0];
        n.dest = instruction[15:12];
        return n;
    endfunction

    task automatic checkState(input string who, input exp_t o, input exp_t e);
        checkOutput({who, ".ctrl"}, 64'({o.ov, o.wb, o.mr, o.mw, o.b, o.s, o.exe}),
                    64'({e.ov, e.wb, e.mr, e.mw, e.b, e.s, e.exe}));
        checkOutput({who, ".pc"},  64'(o.pc),  64'(e.pc));
        checkOutput({who, ".vrn"}, 64'(o.vrn), 64'(e.vrn));
        checkOutput({who, ".vrm"}, 64'(o.vrm), 64'(e.vrm));
        checkOutput({who, ".fields"}, 64'({o.sh, o.imm, o.i24, o.dest}),
                    64'({e.sh, e.imm, e.i24, e.dest}));
    endtask

    // One clock of stimulus: drive, check hazard-unit outputs, step the model,
    // then check both stages half a cycle after the edge.
    task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] p,
                                 input logic [31:0] ins, input logic hz, input logic st,
                                 input logic fl, input logic [3:0] flags, input logic we,
                                 input logic [3:0] wd, input logic [31:0] wv);
        bit str;
        rst = r; in_valid = iv; pc_in = p; instruction = ins; hazard = hz;
        stall = st; flush = fl; sr = flags; wb_wb_en = we; wb_dest = wd; wb_value = wv;
        #1;
        str = (ins[27:26] == 2'b01) && !ins[20];
        checkOutput("srcs", 64'({a_two_src, a_src_1, a_src_2}),
                    64'({!ins[25] || str, ins[19:16], str ? ins[15:12] : ins[3:0]}));
        expA = modelNext(expA, 1'b0);
        expB = modelNext(expB, 1'b1);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) begin regsA[i] = '0; regsB[i] = '0; end
        end else if (we) begin
            regsA[wd] = wv;
            if (wd < 8) regsB[wd] = wv;
        end
        @(negedge clk);
        checkState("A", obsA, expA);
        checkState("B", obsB, expB);
    endtask

    initial begin
        logic [31:0] ri;
        for (int i = 0; i < 16; i++) begin
            opKnown[i] = 0; opWb[i] = 0; opExe[i] = 4'b0000; regsA[i] = '0; regsB[i] = '0;
        end
        opExe[13] = 4'b0001; opExe[15] = 4'b1001; opExe[4]  = 4'b0010; opExe[5] = 4'b0011;
        opExe[2]  = 4'b0100; opExe[6]  = 4'b0101; opExe[0]  = 4'b0110; opExe[12] = 4'b0111;
        opExe[1]  = 4'b1000; opExe[10] = 4'b0100; opExe[8]  = 4'b0110;
        foreach (opKnown[i]) opKnown[i] = (i inside {0, 1, 2, 4, 5, 6, 8, 10, 12, 13, 15});
        foreach (opWb[i])    opWb[i]    = (i inside {0, 1, 2, 4, 5, 6, 12, 13, 15});
        expA = '0; expB = '0;

        // Reset
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h44, 32'hE0821003, 0, 0, 0, 0, 1, 4'd3, 32'h55);
        checkOutput("reset.ctrl", 64'({obsA.ov, obsA.wb, obsA.exe}), 64'h0);
        checkOutput("reset.pc", 64'(obsA.pc), 64'h0);

        // ADD r1,r2,r3 with a same-cycle write to r2
        applyStimulus(0, 1, 32'h100, 32'hE0821003, 0, 0, 0, 4'b0000, 1, 4'd2, 32'hDEADBEEF);
        checkOutput("add.src2", 64'({a_two_src, a_src_2}), 64'({1'b1, 4'd3}));
        checkOutput("add.valid", 64'(obsA.ov), 64'(1));
        checkOutput("add.exe", 64'(obsA.exe), 64'(4'b0010));
        checkOutput("add.wb", 64'(obsA.wb), 64'(1));
        checkOutput("add.dest", 64'(obsA.dest), 64'(4'd1));
        checkOutput("bypass.on", 64'(obsA.vrn), 64'h0000_0000_DEAD_BEEF);
        checkOutput("bypass.off", 64'(obsB.vrn), 64'h0);

        // Preload the register file
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'(i), $urandom);
        end

        // STR r4,[r5]
        applyStimulus(0, 1, 32'h104, 32'hE5854000, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("str.src", 64'({a_two_src, a_src_2}), 64'({1'b1, 4'd4}));
        checkOutput("str.mem", 64'({obsA.mw, obsA.wb}), 64'({1'b1, 1'b0}));

        // ADDEQ with Z clear: valid but no side effects
        applyStimulus(0, 1, 32'h108, 32'h00821003, 0, 0, 0, 4'b0000, 0, 0, 0);
        checkOutput("eq.valid", 64'(obsA.ov), 64'(1));
        checkOutput("eq.ctrl", 64'({obsA.wb, obsA.mr, obsA.mw, obsA.b, obsA.s, obsA.exe}), 64'h0);

        // Stall freezes outputs, then flush beats stall
        applyStimulus(0, 1, 32'h10C, 32'hE0821003, 0, 0, 0, 0, 0, 0, 0);
        frozen = obsA;
        for (int i = 0; i < 3; i++) begin
            ri = $urandom;
            applyStimulus(0, 1, $urandom, ri, 0, 1, 0, 4'(ri), 0, 0, 0);
            checkState("stall", obsA, frozen);
        end
        applyStimulus(0, 1, 32'h110, 32'hE0821003, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("flush.ctrl", 64'({obsA.ov, obsA.wb, obsA.exe}), 64'h0);

        // Reset during stall with a write to r7: write discarded
        applyStimulus(1, 1, 32'h114, 32'hE0821003, 0, 1, 0, 0, 1, 4'd7, 32'h12345678);
        checkOutput("rststall.ctrl", 64'({obsA.ov, obsA.wb, obsA.exe}), 64'h0);
        applyStimulus(0, 1, 32'h118, 32'hE0871003, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rststall.r7", 64'(obsA.vrn), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ri = $urandom;
            if ($urandom_range(0, 1) == 1) ri[31:28] = 4'hE;
            applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 9) != 0, $urandom, ri,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                          $urandom_range(0, 9) == 0, 4'($urandom), 1'($urandom),
                          4'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
